fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Controller for the instruction-fetch stage. It owns the PC register, selects the next PC (sequential, branch or jump), and runs a request/acknowledge handshake with a variable-latency instruction memory. It delivers fetched instructions to Instruction Decode through one output register that honours the hazard stall. It also flushes wrong-path fetches when a branch or jump redirect arrives.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, sequential increment in bytes
TIMEOUT_CYCLES, 255, maximum wait for imemAck; used only with FETCH_TIMEOUT_EN

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
hazard  input  1  decode stall; output register is not consumed while 1
branchTakenInput  input  1  branch redirect request from ID
pcBranchInput  input  32  branch target
jumpInput  input  1  jump redirect request from ID
pcJumpInput  input  32  jump target
imemReq  output  1  fetch request to instruction memory
imemAddr  output  32  fetch address
imemAck  input  1  data valid on imemData; one cycle per request
imemData  input  32  fetched instruction
instructionOutput  output  32  instruction to ID
pc4Output  output  32  fetched PC + PC_STEP
validOutput  output  1  instructionOutput/pc4Output hold a live instruction
fetchErrorOutput  output  1  sticky fetch timeout flag

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; pc=RESET_PC; imemReq=0; validOutput=0; instructionOutput=0; pc4Output=0; pending target=0; fetchErrorOutput=0.
- Redirect = jumpInput | branchTakenInput. Target = pcJumpInput if jumpInput, else pcBranchInput. Jump has priority.
- Consume = validOutput & ~hazard. On a consume with no new capture in the same cycle, validOutput<=0.
- Every redirect clears validOutput at the same edge. Redirect overrides consume.
- Arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
- Handshake: imemReq=1 means imemAddr=pc. Once imemReq is asserted, imemAddr stays stable until imemAck. imemAck while imemReq=0 is ignored.
- IDLE: imemReq=0; next cycle goes to REQ. First request is issued 1 cycle after reset release.
- REQ: imemReq=1.
  - ack & redirect: discard imemData; pc<=target; stay REQ.
  - ack & no redirect & (validOutput=0 or hazard=0): instructionOutput<=imemData; pc4Output<=pc+PC_STEP; validOutput<=1; pc<=pc+PC_STEP; stay REQ. With a single-cycle memory this gives back-to-back throughput of 1 instruction/cycle.
  - ack & no redirect & validOutput=1 & hazard=1: store imemData and pc+PC_STEP in the hold buffer; go to FULL.
  - no ack & redirect: pending<=target; go to DRAIN.
- FULL: imemReq=0.
  - redirect: drop buffer; pc<=target; go to REQ.
  - hazard=0: output register<=buffer; validOutput=1; pc<=pc+PC_STEP; go to REQ.
- DRAIN: imemReq=1 with the old address.
  - Another redirect: pending<=new target (latest wins).
  - ack: discard imemData; pc<=pending, or the same-cycle redirect target if present; go to REQ.
- Latency: ack edge to validOutput=1 is 1 edge. Redirect to first request at the target is 1 cycle (REQ/FULL) or ack+1 (DRAIN).
- Reset asserted mid-transaction aborts everything immediately. A late imemAck arriving after reset is ignored while in IDLE.

Optional Feature:
FETCH_TIMEOUT_EN
- Defined: a counter clears on each new request and increments each cycle imemReq=1 & imemAck=0.
  - When it reaches TIMEOUT_CYCLES: fetchErrorOutput<=1 (sticky until reset), state<=IDLE, validOutput<=0, pc unchanged. Fetch retries the same address.
- Undefined: no counter; fetchErrorOutput is tied to 0.

Test Plan:
- Reset release with single-cycle memory returning ack every cycle -> imemAddr 0,4,8,12 on consecutive cycles; validOutput=1 from cycle 2; pc4Output 4,8,12.
- hazard=1 for 3 cycles while validOutput=1 and ack arrives -> FULL, imemReq=0, output frozen. hazard drop -> buffered instruction appears next edge, fetch resumes at the next PC.
- Memory latency 3 cycles, branchTakenInput=1 with pcBranchInput=0x40 in cycle 1 of the wait -> DRAIN; old data discarded; next imemAddr=0x40; validOutput stays 0 in between.
- jumpInput=1 (0x100) and branchTakenInput=1 (0x80) in the same cycle -> next imemAddr=0x100.
- Assert reset=0 mid-wait with imemReq=1 -> outputs zero immediately. Release -> imemAddr=RESET_PC; a stale ack is ignored.
- FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=8 and no ack -> fetchErrorOutput=1 after 8 cycles, then retry at the same address. Without the macro -> fetchErrorOutput stays 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch PC sequencer with imem handshake and decode output register
// Optional feature macro: FETCH_TIMEOUT_EN (sticky fetch timeout with retry of the same address)
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter logic [31:0] PC_STEP        = 32'd4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hazard,
  input  logic        branchTakenInput,
  input  logic [31:0] pcBranchInput,
  input  logic        jumpInput,
  input  logic [31:0] pcJumpInput,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemAck,
  input  logic [31:0] imemData,
  output logic [31:0] instructionOutput,
  output logic [31:0] pc4Output,
  output logic        validOutput,
  output logic        fetchErrorOutput
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_FULL,
    S_DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_pc4_q, buf_pc4_d;
  logic [31:0] pending_q, pending_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_next_seq;
  logic        consume;
  logic        req;
  logic        timeout;

  // Jump wins over branch when both redirect in the same cycle.
  assign redirect    = jumpInput | branchTakenInput;
  assign target      = jumpInput ? pcJumpInput : pcBranchInput;
  assign pc_next_seq = pc_q + PC_STEP;
  assign consume     = valid_q & ~hazard;
  // In DRAIN the request stays up at the old address until memory answers.
  assign req         = (state_q == S_REQ) || (state_q == S_DRAIN);

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  assign timeout = req & ~imemAck & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count unanswered request cycles; any ack or idle cycle restarts the count.
  always_comb begin
    cnt_d = '0;
    err_d = err_q | timeout;
    if (req && !imemAck && !timeout) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Timeout counter and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign fetchErrorOutput = err_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
  assign fetchErrorOutput   = 1'b0;
`endif

  // Next-state, PC selection and output-register update.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    buf_instr_d = buf_instr_q;
    buf_pc4_d   = buf_pc4_q;
    pending_d   = pending_q;

    if (consume) begin
      valid_d = 1'b0;
    end
    if (redirect) begin
      valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (imemAck) begin
          if (redirect) begin
            pc_d = target;
          end else if (!valid_q || !hazard) begin
            instr_d = imemData;
            pc4_d   = pc_next_seq;
            valid_d = 1'b1;
            pc_d    = pc_next_seq;
          end else begin
            // Decode is stalled on a live instruction: park the new one.
            buf_instr_d = imemData;
            buf_pc4_d   = pc_next_seq;
            state_d     = S_FULL;
          end
        end else if (redirect) begin
          pending_d = target;
          state_d   = S_DRAIN;
        end
      end
      S_FULL: begin
        if (redirect) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (!hazard) begin
          instr_d = buf_instr_q;
          pc4_d   = buf_pc4_q;
          valid_d = 1'b1;
          pc_d    = pc_next_seq;
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect) begin
          pending_d = target;
        end
        if (imemAck) begin
          pc_d    = redirect ? target : pending_q;
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A timed-out fetch restarts from IDLE at the same address.
    if (timeout) begin
      state_d = S_IDLE;
      valid_d = 1'b0;
      pc_d    = pc_q;
    end
  end

  // State, PC and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      pc4_q       <= '0;
      valid_q     <= 1'b0;
      buf_instr_q <= '0;
      buf_pc4_q   <= '0;
      pending_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc4_q   <= buf_pc4_d;
      pending_q   <= pending_d;
    end
  end

  assign imemReq           = req;
  assign imemAddr          = pc_q;
  assign instructionOutput = instr_q;
  assign pc4Output         = pc4_q;
  assign validOutput       = valid_q;

endmodule
